// File: rtl/ball_physics_stepper.sv
// ball_physics_stepper: per-frame billiard update (cue hit, integrate, walls, pairwise elastic swap).
// Define FRICTION_EN to add per-frame velocity decay during integration.
module ball_physics_stepper #(
  parameter int WIDTH = 32,
  parameter int FRAC_WIDTH = 30,
  parameter int N_BALLS = 4,
  parameter int DT_SHIFT = 4,
  parameter int HIT_SHIFT = 2,
  parameter int FRIC_SHIFT = 8,
  parameter logic signed [WIDTH-1:0] RADIUS = 32'h0200_0000,
  parameter logic signed [WIDTH-1:0] X_MIN = 32'hC000_0000,
  parameter logic signed [WIDTH-1:0] X_MAX = 32'h4000_0000,
  parameter logic signed [WIDTH-1:0] Y_MIN = 32'hE000_0000,
  parameter logic signed [WIDTH-1:0] Y_MAX = 32'h2000_0000,
  localparam int IDX_W = $clog2(N_BALLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             hit_valid,
  input  logic [WIDTH-1:0] hit_x,
  input  logic [WIDTH-1:0] hit_y,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_x,
  input  logic [WIDTH-1:0] wr_y,
  input  logic [WIDTH-1:0] wr_vx,
  input  logic [WIDTH-1:0] wr_vy,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_x,
  output logic [WIDTH-1:0] rd_y,
  output logic [WIDTH-1:0] rd_vx,
  output logic [WIDTH-1:0] rd_vy
);
  localparam int WW = 2 * WIDTH + 1;
  localparam logic signed [WIDTH-1:0] XLO = X_MIN + RADIUS;
  localparam logic signed [WIDTH-1:0] XHI = X_MAX - RADIUS;
  localparam logic signed [WIDTH-1:0] YLO = Y_MIN + RADIUS;
  localparam logic signed [WIDTH-1:0] YHI = Y_MAX - RADIUS;
  localparam logic signed [WW-1:0] DIAM_W = WW'(RADIUS) <<< 1;
  localparam logic signed [WW-1:0] DIAM2 = DIAM_W * DIAM_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BALLS - 1);
  localparam logic [IDX_W-1:0] PENULT = IDX_W'(N_BALLS - 2);

  typedef enum logic [2:0] {IDLE, HIT, INTEG, PAIR_D, PAIR_A, FIN} state_t;
  state_t state, state_n;

  logic signed [WIDTH-1:0] px [N_BALLS];
  logic signed [WIDTH-1:0] py [N_BALLS];
  logic signed [WIDTH-1:0] vx [N_BALLS];
  logic signed [WIDTH-1:0] vy [N_BALLS];
  logic signed [WIDTH-1:0] hx, hy;
  logic pend, ovl;
  logic [IDX_W-1:0] k, bi, bj;

  logic unused_cfg;
  assign unused_cfg = ^{FRAC_WIDTH, FRIC_SHIFT};

  // Position step with wall clamp; reflected velocity always points back into the table.
  function automatic logic [2*WIDTH-1:0] step(input logic signed [WIDTH-1:0] p, v, lo, hi);
    logic signed [WIDTH-1:0] np, nv;
    np = p + (v >>> DT_SHIFT);
    nv = v;
    if (np > hi) begin
      np = hi;
      nv = v < 0 ? v : -v;
    end else if (np < lo) begin
      np = lo;
      nv = v < 0 ? -v : v;
    end
`ifdef FRICTION_EN
    nv = nv - (nv >>> FRIC_SHIFT);
`endif
    return {np, nv};
  endfunction

  logic signed [WIDTH-1:0] hdx, hdy, ix, iy, ivx, ivy, dx, dy, dvx, dvy;
  logic signed [WW-1:0] dist2, dot;
  logic overlap, approach;

  assign hdx = (hit_valid ? hit_x : hx) - px[0];
  assign hdy = (hit_valid ? hit_y : hy) - py[0];
  assign {ix, ivx} = step(px[k], vx[k], XLO, XHI);
  assign {iy, ivy} = step(py[k], vy[k], YLO, YHI);
  assign dx = px[bj] - px[bi];
  assign dy = py[bj] - py[bi];
  assign dvx = vx[bj] - vx[bi];
  assign dvy = vy[bj] - vy[bi];
  assign dist2 = WW'(dx) * WW'(dx) + WW'(dy) * WW'(dy);
  assign dot = WW'(dx) * WW'(dvx) + WW'(dy) * WW'(dvy);
  assign overlap = dist2 < DIAM2;
  assign approach = dot[WW-1];

  assign busy = state != IDLE;
  assign done = state == FIN;
  assign rd_x = px[rd_idx];
  assign rd_y = py[rd_idx];
  assign rd_vx = vx[rd_idx];
  assign rd_vy = vy[rd_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? HIT : IDLE;
      HIT:     state_n = INTEG;
      INTEG:   state_n = k == LAST ? PAIR_D : INTEG;
      PAIR_D:  state_n = PAIR_A;
      PAIR_A:  state_n = (bi == PENULT && bj == LAST) ? FIN : PAIR_D;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < N_BALLS; n++) begin
        px[n] <= '0;
        py[n] <= '0;
        vx[n] <= '0;
        vy[n] <= '0;
      end
      hx <= '0;
      hy <= '0;
      pend <= 1'b0;
      ovl <= 1'b0;
      k <= '0;
      bi <= '0;
      bj <= IDX_W'(1);
    end else begin
      if (hit_valid && state != HIT) begin
        pend <= 1'b1;
        hx <= hit_x;
        hy <= hit_y;
      end
      case (state)
        IDLE: begin
          if (wr_en) begin
            px[wr_idx] <= wr_x;
            py[wr_idx] <= wr_y;
            vx[wr_idx] <= wr_vx;
            vy[wr_idx] <= wr_vy;
          end
          k <= '0;
          bi <= '0;
          bj <= IDX_W'(1);
        end
        HIT: begin
          if (hit_valid || pend) begin
            vx[0] <= vx[0] + (hdx >>> HIT_SHIFT);
            vy[0] <= vy[0] + (hdy >>> HIT_SHIFT);
          end
          pend <= 1'b0;
        end
        INTEG: begin
          px[k] <= ix;
          py[k] <= iy;
          vx[k] <= ivx;
          vy[k] <= ivy;
          k <= k + IDX_W'(1);
        end
        PAIR_D: ovl <= overlap;
        PAIR_A: begin
          if (ovl && approach) begin
            vx[bi] <= vx[bj];
            vx[bj] <= vx[bi];
            vy[bi] <= vy[bj];
            vy[bj] <= vy[bi];
          end
          if (bj == LAST) begin
            bi <= bi + IDX_W'(1);
            bj <= bi + IDX_W'(2);
          end else bj <= bj + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end
endmodule
